// File: rtl/privilege_mode_controller.sv
// rtl/privilege_mode_controller.sv - machine/user privilege FSM with trap, redirect and flush sequencing
module privilege_mode_controller #(
    parameter int          CORE         = 0,
    parameter int          ADDRESS_BITS = 32,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    inst_valid,
    input  logic [6:0]              opcode,
    input  logic [2:0]              funct3,
    input  logic [11:0]             funct12,
    input  logic [ADDRESS_BITS-1:0] pc,
    output logic                    user_mode,
    output logic                    redirect_valid,
    output logic [ADDRESS_BITS-1:0] redirect_pc,
    output logic                    flush,
    output logic [ADDRESS_BITS-1:0] epc,
    output logic [3:0]              cause,
    output logic [15:0]             trap_count,
    input  logic                    report
);

    localparam logic [1:0] ST_MACHINE = 2'd0;
    localparam logic [1:0] ST_USER    = 2'd1;
    localparam logic [1:0] ST_FLUSH   = 2'd2;

    localparam logic [6:0] OP_USERMODE = 7'b0001011;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    localparam logic [ADDRESS_BITS-1:0] TRAP_PC    = ADDRESS_BITS'(TRAP_VECTOR);
    localparam logic [3:0]              FLUSH_LOAD = 4'(FLUSH_CYCLES);

    logic [1:0]              state;
    logic [3:0]              flush_left;
    logic                    legal;
    logic                    accepted;
    logic                    in_user;
    logic                    take_trap;
    logic                    enter_user;
    logic [3:0]              trap_cause;
    logic [ADDRESS_BITS-1:0] user_target;

    // report only drives simulation tracing in the core model; no hardware depends on it
    logic unused_ok;
    assign unused_ok = report | (CORE < 0);

    always_comb begin
        legal = 1'b0;
        case (opcode)
            7'b0110011, 7'b0010011, 7'b0100011, 7'b0000011,
            7'b1100011, 7'b1100111, 7'b1101111, 7'b0010111,
            7'b0110111, 7'b0001111, 7'b1110011, 7'b0001011: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        accepted    = inst_valid && (state != ST_FLUSH);
        in_user     = (state == ST_USER);
        take_trap   = 1'b0;
        enter_user  = 1'b0;
        trap_cause  = 4'd0;
        user_target = pc + ADDRESS_BITS'(4);
        if (accepted) begin
            if (!legal) begin
                take_trap  = 1'b1;
                trap_cause = 4'd2;
            end else if (opcode == OP_USERMODE) begin
                if (in_user) begin
                    take_trap  = 1'b1;
                    trap_cause = 4'd2;
                end else begin
                    enter_user = 1'b1;
                end
            end else if (opcode == OP_SYSTEM && funct3 == 3'd0 && funct12 == 12'h000) begin
                take_trap  = 1'b1;
                trap_cause = in_user ? 4'd8 : 4'd11;
            end else if (opcode == OP_SYSTEM && funct3 == 3'd0 && funct12 == 12'h302) begin
                if (in_user) begin
                    take_trap  = 1'b1;
                    trap_cause = 4'd2;
                end else begin
                    enter_user  = 1'b1;
                    user_target = epc;
                end
            end else if (opcode == OP_SYSTEM && funct3 != 3'd0 && in_user) begin
                take_trap  = 1'b1;
                trap_cause = 4'd2;
            end
        end
    end

    // user_mode doubles as the return privilege held through FLUSH
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= ST_MACHINE;
            flush_left     <= 4'd0;
            user_mode      <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush          <= 1'b0;
            epc            <= '0;
            cause          <= 4'd0;
            trap_count     <= 16'd0;
        end else begin
            redirect_valid <= 1'b0;
            if (take_trap) begin
                epc            <= pc;
                cause          <= trap_cause;
                redirect_pc    <= TRAP_PC;
                user_mode      <= 1'b0;
                redirect_valid <= 1'b1;
                flush          <= 1'b1;
                state          <= ST_FLUSH;
                flush_left     <= FLUSH_LOAD;
                if (trap_count != 16'hFFFF) begin
                    trap_count <= trap_count + 16'd1;
                end
            end else if (enter_user) begin
                user_mode      <= 1'b1;
                redirect_pc    <= user_target;
                redirect_valid <= 1'b1;
                flush          <= 1'b1;
                state          <= ST_FLUSH;
                flush_left     <= FLUSH_LOAD;
            end else if (state == ST_FLUSH) begin
                if (flush_left <= 4'd1) begin
                    flush      <= 1'b0;
                    flush_left <= 4'd0;
                    state      <= user_mode ? ST_USER : ST_MACHINE;
                end else begin
                    flush_left <= flush_left - 4'd1;
                end
            end
        end
    end

endmodule
